// File: rtl/bcd_display_pkg.sv
// Shared constants, state type and helpers for the binary-to-BCD display path.
package bcd_display_pkg;

   localparam int unsigned DEF_BIN_W  = 20;
   localparam int unsigned DEF_DIGITS = 6;

   // Segment pattern for a blanked digit (active-low segments, all off)
   localparam logic [7:0] DISP_OFF = 8'hFF;

   // Double-dabble correction: digits at or above ADJ_MIN get ADJ_ADD
   localparam logic [3:0] ADJ_MIN = 4'd5;
   localparam logic [3:0] ADJ_ADD = 4'd3;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_e;

   // 10^n, used to derive the largest displayable value
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Blanking mux applied in front of each seven-segment digit
   function automatic logic [7:0] seg_mask(input logic [7:0] seg, input logic blank);
      return blank ? DISP_OFF : seg;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more.
module bcd_digit_adj
   import bcd_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted_c
);

   // Per-nibble correction, no carry out of the nibble
   always_comb begin
      adjusted_c = (digit >= ADJ_MIN) ? 4'(digit + ADJ_ADD) : digit;
   end

endmodule

// File: rtl/bcd_display_converter.sv
// Sequential double-dabble converter producing saturated BCD digits,
// a leading-zero blanking mask and an overflow flag for the HEX displays.
module bcd_display_converter
   import bcd_display_pkg::*;
#(
   parameter int unsigned BIN_W  = DEF_BIN_W,
   parameter int unsigned DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic [DIGITS-1:0]     blank_o,
   output logic                  overflow_o
);

   localparam int unsigned     BCD_W     = 4 * DIGITS;
   localparam int unsigned     CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam longint unsigned MAX_VAL   = pow10(DIGITS) - 64'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   state_e             state_q, state_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic               busy_d, done_d, overflow_d;
   logic [BCD_W-1:0]   bcd_d;
   logic [DIGITS-1:0]  blank_d;

   logic [BCD_W-1:0]       adj_c;
   logic [BCD_W+BIN_W-1:0] shifted_c;
   logic [BCD_W-1:0]       scratch_nx_c;
   logic [DIGITS-1:0]      blank_nx_c;
   logic                   in_ovf_c;
   logic [BIN_W-1:0]       sat_c;

   // Add-3 correction on every scratch digit
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit      (scratch_q[4*g +: 4]),
         .adjusted_c (adj_c[4*g +: 4])
      );
   end

   // Corrected scratch and binary shift left together; binary MSB enters scratch
   assign shifted_c    = {adj_c, shift_q} << 1;
   assign scratch_nx_c = shifted_c[BCD_W+BIN_W-1:BIN_W];

   // Input saturation to the largest displayable value
   assign in_ovf_c = 64'(bin_i) > MAX_VAL;
   assign sat_c    = in_ovf_c ? BIN_W'(MAX_VAL) : bin_i;

   // Leading-zero mask: digit k blanks when it and every higher digit are zero
   always_comb begin
      logic all_zero;
      blank_nx_c = '0;
      all_zero   = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero      = all_zero & (scratch_nx_c[4*k +: 4] == 4'd0);
         blank_nx_c[k] = all_zero;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      busy_d     = busy_o;
      done_d     = 1'b0;
      bcd_d      = bcd_o;
      blank_d    = blank_o;
      overflow_d = overflow_o;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               shift_d    = sat_c;
               ovf_pend_d = in_ovf_c;
               scratch_d  = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = CONVERT;
            end
         end
         CONVERT: begin
            shift_d   = shifted_c[BIN_W-1:0];
            scratch_d = scratch_nx_c;
            cnt_d     = CNT_W'(cnt_q + CNT_W'(1));
            if (cnt_q == CNT_LAST) begin
               bcd_d      = scratch_nx_c;
               blank_d    = blank_nx_c;
               overflow_d = ovf_pend_q;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               cnt_d      = '0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         bcd_o      <= '0;
         blank_o    <= BLANK_RST;
         overflow_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         busy_o     <= busy_d;
         done_o     <= done_d;
         bcd_o      <= bcd_d;
         blank_o    <= blank_d;
         overflow_o <= overflow_d;
      end
   end

endmodule
